// File: rtl/aux_decimator_if.sv
// Output handshake bundle of aux_decimator: averaged A/B pair plus sequence index.
// OUT_VALID/OUT_READY: a transfer happens on every posedge where both are high;
// data stays stable while OUT_VALID is high and OUT_READY is low.
interface aux_decimator_if #(
  parameter int A_W = 8,
  parameter int B_W = 15
) ();
  logic           OUT_VALID;
  logic           OUT_READY;
  logic [A_W-1:0] OUT_A;
  logic [B_W-1:0] OUT_B;
  logic [15:0]    OUT_SEQ;

  modport master (output OUT_VALID, output OUT_A, output OUT_B, output OUT_SEQ, input OUT_READY);
  modport slave  (input OUT_VALID, input OUT_A, input OUT_B, input OUT_SEQ, output OUT_READY);
endinterface

// File: rtl/aux_decimator.sv
// Box-averages 2^LOG2N AUX_A/AUX_B samples per channel and queues the averaged
// pairs in a show-ahead FIFO; pairs that find the FIFO full are dropped and counted.
module aux_decimator #(
  parameter int LOG2N      = 5,
  parameter int DEPTH_LOG2 = 2,
  parameter int A_W        = 8,
  parameter int B_W        = 15
) (
  input  logic                  CLK,
  input  logic                  n_RES,
  input  logic                  SMP_EN,
  input  logic [A_W-1:0]        AUX_A,
  input  logic [B_W-1:0]        AUX_B,
  aux_decimator_if.master       out_if,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic [7:0]            OVF_CNT
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int N     = 1 << LOG2N;
  // A one-bit counter is kept for LOG2N=0; it stays at 0 so every strobe closes a window.
  localparam int CNT_W = (LOG2N > 0) ? LOG2N : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(N - 1);
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [A_W+LOG2N-1:0] acc_a, sum_a;
  logic [B_W+LOG2N-1:0] acc_b, sum_b;
  logic [CNT_W-1:0]     cnt;
  logic [15:0]          seq;
  logic [A_W-1:0]       avg_a;
  logic [B_W-1:0]       avg_b;
  logic                 close, push, pop, full, empty, wr_en;

  logic [DEPTH_LOG2:0]   wr_ptr, rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
  logic [A_W-1:0]        mem_a   [DEPTH];
  logic [B_W-1:0]        mem_b   [DEPTH];
  logic [15:0]           mem_seq [DEPTH];

  always_comb begin
    sum_a = acc_a + (A_W + LOG2N)'(AUX_A);
    sum_b = acc_b + (B_W + LOG2N)'(AUX_B);
    avg_a = A_W'(sum_a >> LOG2N);
    avg_b = B_W'(sum_b >> LOG2N);
    close = (cnt == CNT_LAST);
    push  = SMP_EN & close;
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      acc_a <= '0;
      acc_b <= '0;
      cnt   <= '0;
      seq   <= '0;
    end else if (SMP_EN) begin
      if (close) begin
        acc_a <= '0;
        acc_b <= '0;
        cnt   <= '0;
        seq   <= seq + 16'd1;
      end else begin
        acc_a <= sum_a;
        acc_b <= sum_b;
        cnt   <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    wr_idx = wr_ptr[DEPTH_LOG2-1:0];
    rd_idx = rd_ptr[DEPTH_LOG2-1:0];
    LEVEL  = wr_ptr - rd_ptr;
    empty  = (wr_ptr == rd_ptr);
    full   = (LEVEL == LVL_FULL);
    pop    = ~empty & out_if.OUT_READY;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    wr_en  = push & (~full | pop);
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      OVF_CNT <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && !wr_en && OVF_CNT != 8'hFF) OVF_CNT <= OVF_CNT + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_a[wr_idx]   <= avg_a;
      mem_b[wr_idx]   <= avg_b;
      mem_seq[wr_idx] <= seq;
    end
  end

  // Head is read straight from storage; an empty FIFO presents zeros.
  always_comb begin
    out_if.OUT_VALID = ~empty;
    out_if.OUT_A     = empty ? '0 : mem_a[rd_idx];
    out_if.OUT_B     = empty ? '0 : mem_b[rd_idx];
    out_if.OUT_SEQ   = empty ? '0 : mem_seq[rd_idx];
  end
endmodule

// File: tb/tb_aux_decimator.sv
// Bench for aux_decimator: three instances (LOG2N = 0, 2, 5) share clock, reset and data.
module tb_aux_decimator;
  localparam int A_W = 8;
  localparam int B_W = 15;
  localparam int DL  = 2;
  localparam int EW  = A_W + B_W + 16;
  // instance index -> LOG2N: 0 -> 0, 1 -> 2, 2 -> 5
  localparam int K0 = 0;
  localparam int K2 = 1;
  localparam int K5 = 2;

  logic CLK = 1'b0;
  logic n_RES = 1'b0;
  always #5 CLK = ~CLK;

  logic [2:0]     smp_en, ready, valid;
  logic [A_W-1:0] aux_a;
  logic [B_W-1:0] aux_b;
  logic [A_W-1:0] oa  [3];
  logic [B_W-1:0] ob  [3];
  logic [15:0]    os  [3];
  logic [DL:0]    level [3];
  logic [7:0]     ovf [3];

  for (genvar g = 0; g < 3; g++) begin : gen
    localparam int L = (g == 0) ? 0 : (g == 1) ? 2 : 5;
    aux_decimator_if #(.A_W(A_W), .B_W(B_W)) bus ();
    aux_decimator #(.LOG2N(L), .DEPTH_LOG2(DL), .A_W(A_W), .B_W(B_W)) dut (
      .CLK(CLK), .n_RES(n_RES), .SMP_EN(smp_en[g]), .AUX_A(aux_a), .AUX_B(aux_b),
      .out_if(bus.master), .LEVEL(level[g]), .OVF_CNT(ovf[g]));
    assign bus.OUT_READY = ready[g];
    assign valid[g] = bus.OUT_VALID;
    assign oa[g] = bus.OUT_A;
    assign ob[g] = bus.OUT_B;
    assign os[g] = bus.OUT_SEQ;
  end

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] q0[$];
  logic [EW-1:0] q2[$];
  logic [EW-1:0] q5[$];
  logic [15:0] last_seq0 = 16'h1234;
  logic saw_ffff = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_pair(input int k, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                             input logic [15:0] s);
    case (k)
      K0:      q0.push_back({a, b, s});
      K2:      q2.push_back({a, b, s});
      default: q5.push_back({a, b, s});
    endcase
  endtask

  task automatic strobe(input int k, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    smp_en[k] = 1'b1;
    aux_a = a;
    aux_b = b;
    @(posedge CLK);
    #1;
    smp_en[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (level[k] != 0 && n < 40) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk($sformatf("drain%0d_level", k), 64'(level[k]), 64'd0);
  endtask

  // Monitor: every accepted head is compared against the front of its expected queue.
  logic [EW-1:0] mon_exp;
  logic          mon_have;
  always @(negedge CLK) begin
    if (n_RES) begin
      for (int k = 0; k < 3; k++) begin
        if (valid[k] && ready[k]) begin
          mon_have = 1'b0;
          mon_exp  = '0;
          case (k)
            K0: if (q0.size() > 0) begin mon_have = 1'b1; mon_exp = q0.pop_front(); end
            K2: if (q2.size() > 0) begin mon_have = 1'b1; mon_exp = q2.pop_front(); end
            default: if (q5.size() > 0) begin mon_have = 1'b1; mon_exp = q5.pop_front(); end
          endcase
          checks++;
          if (!mon_have) begin
            errors++;
            $display("FAIL pop%0d_unexpected: got a=%0h b=%0h seq=%0h expected no output",
                     k, oa[k], ob[k], os[k]);
          end else if ({oa[k], ob[k], os[k]} !== mon_exp) begin
            errors++;
            $display("FAIL pop%0d_data: got a=%0h b=%0h seq=%0h expected a=%0h b=%0h seq=%0h",
                     k, oa[k], ob[k], os[k], mon_exp[EW-1 -: A_W], mon_exp[15+B_W -: B_W],
                     mon_exp[15:0]);
          end
          if (k == K0) begin
            if (os[k] == 16'hFFFF) saw_ffff = 1'b1;
            last_seq0 = os[k];
          end
        end
      end
    end
  end

  initial begin
    smp_en = '0;
    ready  = '0;
    aux_a  = '0;
    aux_b  = '0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d_valid", k), 64'(valid[k]), 64'd0);
      chk($sformatf("rst%0d_level", k), 64'(level[k]), 64'd0);
      chk($sformatf("rst%0d_ovf", k),   64'(ovf[k]),   64'd0);
      chk($sformatf("rst%0d_data", k),  64'({oa[k], ob[k], os[k]}), 64'd0);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_RES = 1'b1;
    @(posedge CLK);
    #1;

    // Averaging window, LOG2N=2: (10+11+12+13)>>2 = 11
    ready[K2] = 1'b1;
    expect_pair(K2, 8'd11, 15'h7FFF, 16'd0);
    strobe(K2, 8'd10, 15'h7FFF);
    strobe(K2, 8'd11, 15'h7FFF);
    strobe(K2, 8'd12, 15'h7FFF);
    chk("t1_not_early", 64'(valid[K2]), 64'd0);
    strobe(K2, 8'd13, 15'h7FFF);
    chk("t1_valid", 64'(valid[K2]), 64'd1);
    chk("t1_out_a", 64'(oa[K2]), 64'd11);
    @(posedge CLK);
    #1;
    chk("t1_valid_drop", 64'(valid[K2]), 64'd0);

    // Full-scale window and truncation, LOG2N=5
    ready[K5] = 1'b1;
    expect_pair(K5, 8'hFF, 15'h7FFF, 16'd0);
    for (int i = 0; i < 32; i++) strobe(K5, 8'hFF, 15'h7FFF);
    expect_pair(K5, 8'd0, 15'd1, 16'd1);
    for (int i = 0; i < 32; i++) strobe(K5, (i % 2 == 0) ? 8'd1 : 8'd0, (i % 2 == 0) ? 15'd3 : 15'd0);
    drain(K5);

    // Backpressure and overflow, LOG2N=0: 4 stored, 2 dropped
    ready[K0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) expect_pair(K0, A_W'(i + 1), B_W'(i + 100), 16'(i));
      strobe(K0, A_W'(i + 1), B_W'(i + 100));
    end
    chk("t3_level", 64'(level[K0]), 64'd4);
    chk("t3_ovf", 64'(ovf[K0]), 64'd2);

    // Full FIFO with push and pop together: no drop, seq 6 lands at the tail
    ready[K0] = 1'b1;
    expect_pair(K0, 8'h55, 15'h155, 16'd6);
    strobe(K0, 8'h55, 15'h155);
    chk("t4_level", 64'(level[K0]), 64'd4);
    chk("t4_ovf", 64'(ovf[K0]), 64'd2);
    drain(K0);

    // Async reset mid-window
    ready[K0] = 1'b0;
    strobe(K0, 8'h33, 15'h44);
    chk("t5_pre_level", 64'(level[K0]), 64'd1);
    for (int i = 0; i < 3; i++) strobe(K2, 8'd5, 15'd5);
    @(posedge CLK);
    #2;
    n_RES = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(valid[K0]), 64'd0);
    chk("t5_rst_level", 64'(level[K0]), 64'd0);
    chk("t5_rst_ovf", 64'(ovf[K0]), 64'd0);
    chk("t5_rst_data", 64'({oa[K0], ob[K0], os[K0]}), 64'd0);
    q0.delete();
    q2.delete();
    q5.delete();
    #1;
    n_RES = 1'b1;
    @(posedge CLK);
    #1;
    expect_pair(K2, 8'd8, 15'd8, 16'd0);
    for (int i = 0; i < 4; i++) strobe(K2, 8'd8, 15'd8);
    chk("t5_valid", 64'(valid[K2]), 64'd1);
    chk("t5_seq", 64'(os[K2]), 64'd0);
    drain(K2);

    // Sequence wrap: 65537 passthrough pushes drained one per cycle
    ready[K0] = 1'b1;
    for (int i = 0; i <= 65536; i++) begin
      expect_pair(K0, A_W'(i), B_W'(i), 16'(i));
      strobe(K0, A_W'(i), B_W'(i));
    end
    drain(K0);
    chk("t6_saw_ffff", 64'(saw_ffff), 64'd1);
    chk("t6_wrap_seq", 64'(last_seq0), 64'd0);

    // OVF saturation: 4 stored then 300 drops
    ready[K0] = 1'b0;
    for (int i = 0; i < 304; i++) begin
      if (i < 4) expect_pair(K0, A_W'(i), 15'd0, 16'(i + 1));
      strobe(K0, A_W'(i), 15'd0);
    end
    chk("t6_ovf_sat", 64'(ovf[K0]), 64'd255);
    chk("t6_level", 64'(level[K0]), 64'd4);
    ready[K0] = 1'b1;
    drain(K0);
    chk("t6_ovf_hold", 64'(ovf[K0]), 64'd255);

    repeat (3) @(posedge CLK);
    chk("queues_empty", 64'(q0.size() + q2.size() + q5.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
